// File: rtl/fp9_pkg.sv
// Shared constants for the FP8 -> FP9 (E5M3) operand widening path.
package fp9_pkg;

  // Source format selector encodings; 2 and 3 are reserved.
  localparam logic [1:0] FMT_E4M3 = 2'd0;
  localparam logic [1:0] FMT_E5M2 = 2'd1;

  // Element widths on either side of the converter.
  localparam int FP8_W = 8;
  localparam int FP9_W = 9;

  // Canonical quiet NaN in E5M3 without its sign bit: exp all ones, mant 100.
  localparam logic [7:0] FP9_NAN_CANON = 8'hFC;

  // E4M3 has bias 7, E5M3 has bias 15.
  localparam logic [4:0] E4M3_TO_E5M3_BIAS_ADJ = 5'd8;

endpackage : fp9_pkg

// File: rtl/fp8_to_fp9_lane.sv
// Combinational widening of one FP8 element (E4M3 or E5M2) to FP9 E5M3.
module fp8_to_fp9_lane
  import fp9_pkg::*;
(
  input  logic [1:0]       fmt_i,
  input  logic [FP8_W-1:0] in_i,
  output logic [FP9_W-1:0] out_o,
  output logic             is_nan_o,
  output logic             fmt_err_o
);

  logic       sgn;
  logic [4:0] e4_norm_exp;

  assign sgn         = in_i[7];
  assign e4_norm_exp = {1'b0, in_i[6:3]} + E4M3_TO_E5M3_BIAS_ADJ;

  // Format-dependent re-encoding; reserved formats yield zero and flag an error.
  always_comb begin
    out_o     = '0;
    is_nan_o  = 1'b0;
    fmt_err_o = 1'b0;
    case (fmt_i)
      FMT_E5M2: begin
        // Same exponent bias: just append a zero mantissa LSB (inf/NaN preserved).
        out_o    = {in_i, 1'b0};
        is_nan_o = (in_i[6:2] == 5'h1F) && (in_i[1:0] != 2'b00);
      end
      FMT_E4M3: begin
        if (in_i[6:0] == 7'h7F) begin
          out_o    = {sgn, FP9_NAN_CANON};
          is_nan_o = 1'b1;
        end else if (in_i[6:3] != 4'h0) begin
          out_o = {sgn, e4_norm_exp, in_i[2:0]};
        end else begin
          // E4M3 subnormals are normal numbers in E5M3: shift the leading one out.
          casez (in_i[2:0])
            3'b1??:  out_o = {sgn, 5'd8, in_i[1:0], 1'b0};
            3'b01?:  out_o = {sgn, 5'd7, in_i[0], 2'b00};
            3'b001:  out_o = {sgn, 5'd6, 3'b000};
            default: out_o = {sgn, 8'h00};
          endcase
        end
      end
      default: begin
        fmt_err_o = 1'b1;
      end
    endcase
  end

endmodule : fp8_to_fp9_lane

// File: rtl/to_fp9_con_pipe.sv
// Two-stage valid/ready pipeline widening packed FP8 A/B operand buses to FP9 E5M3.
module to_fp9_con_pipe
  import fp9_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             fmt_i,
  input  logic [LANES*FP8_W-1:0] a_i,
  input  logic [LANES*FP8_W-1:0] b_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [LANES*FP9_W-1:0] a_o,
  output logic [LANES*FP9_W-1:0] b_o,
  output logic                   nan_o,
  output logic                   err_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i
);

  localparam int IN_W  = FP8_W;
  localparam int OUT_W = FP9_W;

  // Stage 1: raw operands and their format.
  logic [LANES*IN_W-1:0]  a1_q, b1_q;
  logic [1:0]             fmt1_q;
  logic                   v1_q;

  // Stage 2: converted operands and beat flags.
  logic [LANES*OUT_W-1:0] a2_q, b2_q;
  logic [LANES*OUT_W-1:0] a2_d, b2_d;
  logic                   nan2_q, err2_q;
  logic                   nan2_d, err2_d;
  logic                   v2_q;

  logic [LANES-1:0]       a_nan, b_nan, a_err, b_err;
  logic                   s1_ready, s2_ready;

  // A stage can take a new beat when empty or when its contents move on this cycle.
  assign s2_ready   = !v2_q || out_ready_i;
  assign s1_ready   = !v1_q || s2_ready;
  assign in_ready_o = s1_ready;

  // One converter per lane per bus, all fed from the stage-1 registers.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    fp8_to_fp9_lane u_a (
      .fmt_i     (fmt1_q),
      .in_i      (a1_q[gi*IN_W +: IN_W]),
      .out_o     (a2_d[gi*OUT_W +: OUT_W]),
      .is_nan_o  (a_nan[gi]),
      .fmt_err_o (a_err[gi])
    );
    fp8_to_fp9_lane u_b (
      .fmt_i     (fmt1_q),
      .in_i      (b1_q[gi*IN_W +: IN_W]),
      .out_o     (b2_d[gi*OUT_W +: OUT_W]),
      .is_nan_o  (b_nan[gi]),
      .fmt_err_o (b_err[gi])
    );
  end

  assign nan2_d = |{a_nan, b_nan};
  assign err2_d = |{a_err, b_err};

  // Stage 1 capture: load on every advance, data only when a beat is present.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      fmt1_q <= FMT_E4M3;
    end else if (s1_ready) begin
      v1_q <= in_valid_i;
      if (in_valid_i) begin
        a1_q   <= a_i;
        b1_q   <= b_i;
        fmt1_q <= fmt_i;
      end
    end
  end

  // Stage 2 capture: holds (outputs stable) while downstream stalls a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q   <= 1'b0;
      a2_q   <= '0;
      b2_q   <= '0;
      nan2_q <= 1'b0;
      err2_q <= 1'b0;
    end else if (s2_ready) begin
      v2_q <= v1_q;
      if (v1_q) begin
        a2_q   <= a2_d;
        b2_q   <= b2_d;
        nan2_q <= nan2_d;
        err2_q <= err2_d;
      end
    end
  end

  assign a_o         = a2_q;
  assign b_o         = b2_q;
  assign nan_o       = nan2_q;
  assign err_o       = err2_q;
  assign out_valid_o = v2_q;

endmodule : to_fp9_con_pipe

// File: tb/tb_to_fp9_con_pipe.sv
// Self-checking bench: value-based FP8 -> E5M3 reference model plus scoreboard.
module tb_to_fp9_con_pipe;

  localparam int LANES = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           fmt_i;
  logic [LANES*8-1:0]   a_i, b_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [LANES*9-1:0]   a_o, b_o;
  logic                 nan_o, err_o, out_valid_o;
  logic                 out_ready_i;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;
  bit rand_ready = 1'b0;

  typedef struct packed {
    logic [LANES*9-1:0] a;
    logic [LANES*9-1:0] b;
    logic               nan;
    logic               err;
  } beat_t;

  beat_t exp_q[$];

  to_fp9_con_pipe #(.LANES(LANES)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fmt_i       (fmt_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_o         (a_o),
    .b_o         (b_o),
    .nan_o       (nan_o),
    .err_o       (err_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk = ~clk;

  // Encode the finite value sig * 2^p (sig >= 0) as E5M3 with sign s.
  function automatic logic [8:0] enc_e5m3(input logic s, input int sig, input int p);
    int f;
    if (sig == 0) return {s, 8'h00};
    while (sig < 8) begin
      sig = sig * 2;
      p   = p - 1;
    end
    f = p + 18;  // (8+mant) * 2^(f-15-3)
    if (f >= 1) return {s, 5'(f), 3'(sig - 8)};
    sig = sig >> (1 - f);
    return {s, 5'd0, 3'(sig)};
  endfunction

  // Reference for one element: decode to a numeric value, then re-encode.
  function automatic void ref_lane(input logic [1:0] f, input logic [7:0] x,
                                   output logic [8:0] y, output logic nan);
    logic s;
    int   e, m;
    s   = x[7];
    y   = '0;
    nan = 1'b0;
    if (f == 2'd0) begin
      e = int'(x[6:3]);
      m = int'(x[2:0]);
      if (e == 15 && m == 7) begin
        nan = 1'b1;
        y   = {s, 5'd31, 3'd4};
      end else begin
        y = enc_e5m3(s, (e == 0) ? m : 8 + m, ((e == 0) ? 1 : e) - 10);
      end
    end else if (f == 2'd1) begin
      e = int'(x[6:2]);
      m = int'(x[1:0]);
      if (e == 31) begin
        y   = {s, 5'd31, x[1:0], 1'b0};
        nan = (m != 0);
      end else begin
        y = enc_e5m3(s, (e == 0) ? m : 4 + m, ((e == 0) ? 1 : e) - 17);
      end
    end
  endfunction

  function automatic beat_t ref_beat(input logic [1:0] f, input logic [LANES*8-1:0] a,
                                     input logic [LANES*8-1:0] b);
    beat_t      r;
    logic [8:0] y;
    logic       n;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      ref_lane(f, a[8*k +: 8], y, n);
      r.a[9*k +: 9] = y;
      r.nan = r.nan | n;
      ref_lane(f, b[8*k +: 8], y, n);
      r.b[9*k +: 9] = y;
      r.nan = r.nan | n;
    end
    r.err = (f >= 2'd2);
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, expv);
    end
  endtask

  // Scoreboard: every cycle compare the head beat, ready behaviour, and record accepts.
  always @(negedge clk) begin
    beat_t got;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      n_checks++;
      if (in_ready_o !== ((exp_q.size() < 2) || out_ready_i)) begin
        n_fail++;
        $display("FAIL in_ready: got %b with %0d beats held, out_ready=%b",
                 in_ready_o, exp_q.size(), out_ready_i);
      end
      if (out_valid_o) begin
        n_checks++;
        got.a = a_o; got.b = b_o; got.nan = nan_o; got.err = err_o;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL spurious_beat: out_valid with no beat outstanding, a=%h b=%h", a_o, b_o);
        end else begin
          if (got !== exp_q[0]) begin
            n_fail++;
            $display("FAIL beat_data: got a=%h b=%h nan=%b err=%b, expected a=%h b=%h nan=%b err=%b",
                     a_o, b_o, nan_o, err_o, exp_q[0].a, exp_q[0].b, exp_q[0].nan, exp_q[0].err);
          end
          if (out_ready_i) begin
            $display("deliver #%0d a=%h b=%h nan=%b err=%b", n_deliv, a_o, b_o, nan_o, err_o);
            n_deliv++;
            void'(exp_q.pop_front());
          end
        end
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(ref_beat(fmt_i, a_i, b_i));
    end
  end

  // Randomised downstream ready, enabled only during the random phase.
  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  // Present a beat and hold it until accepted; returns 1 time unit after the accept edge.
  task automatic send(input logic [1:0] f, input logic [LANES*8-1:0] a, input logic [LANES*8-1:0] b);
    int guard = 0;
    fmt_i = f; a_i = a; b_i = b; in_valid_i = 1'b1;
    @(negedge clk);
    while (!in_ready_o) begin
      guard++;
      if (guard > 1000) begin
        chk("send_timeout", 128'(guard), 128'(0));
        break;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  // Single beat into an idle pipe: checks latency and literal outputs.
  task automatic directed(input string name, input logic [1:0] f,
                          input logic [LANES*8-1:0] a, input logic [LANES*8-1:0] b,
                          input logic [LANES*9-1:0] ea, input logic [LANES*9-1:0] eb,
                          input logic en, input logic ee);
    send(f, a, b);
    chk({name, "_lat1"}, 128'(out_valid_o), 128'(0));
    @(posedge clk); #1;
    chk({name, "_lat2"}, 128'(out_valid_o), 128'(1));
    chk({name, "_a"}, 128'(a_o), 128'(ea));
    chk({name, "_b"}, 128'(b_o), 128'(eb));
    chk({name, "_flags"}, 128'({nan_o, err_o}), 128'({en, ee}));
    @(posedge clk); #1;
  endtask

  logic [LANES*8-1:0] bp_a[6], bp_b[6];

  initial begin
    logic [8:0] y;
    logic       n;
    int         idx, cyc, guard, d0;
    bit         acc;

    rst_n = 1'b0; in_valid_i = 1'b0; fmt_i = 2'd0; a_i = '0; b_i = '0; out_ready_i = 1'b1;

    // Pin the model against hand-derived encodings.
    ref_lane(2'd0, 8'h7E, y, n); chk("model_e4m3_norm", 128'({y, n}), 128'({9'h0BE, 1'b0}));
    ref_lane(2'd0, 8'h04, y, n); chk("model_e4m3_sub",  128'({y, n}), 128'({9'h040, 1'b0}));
    ref_lane(2'd1, 8'h7D, y, n); chk("model_e5m2_nan",  128'({y, n}), 128'({9'h0FA, 1'b1}));
    ref_lane(2'd1, 8'h01, y, n); chk("model_e5m2_sub",  128'({y, n}), 128'({9'h002, 1'b0}));
    ref_lane(2'd0, 8'hFF, y, n); chk("model_e4m3_nan",  128'({y, n}), 128'({9'h1FC, 1'b1}));

    repeat (3) @(posedge clk); #1;
    chk("reset_outputs", 128'({out_valid_o, nan_o, err_o, a_o, b_o}), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 128'(in_ready_o), 128'(1));

    directed("e4m3", 2'd0, 32'h7E04_0138, 32'h0,
             {9'h0BE, 9'h040, 9'h030, 9'h078}, 36'h0, 1'b0, 1'b0);
    directed("e5m2", 2'd1, 32'h0, 32'h3C7C_FC7D,
             36'h0, {9'h078, 9'h0F8, 9'h1F8, 9'h0FA}, 1'b1, 1'b0);
    directed("e4m3_nan_zero", 2'd0, 32'h7FFF_8000, 32'h0,
             {9'h0FC, 9'h1FC, 9'h100, 9'h000}, 36'h0, 1'b1, 1'b0);
    directed("reserved", 2'd2, 32'h7FFF_3C7E, 32'h1234_5678, 36'h0, 36'h0, 1'b0, 1'b1);
    directed("after_reserved", 2'd0, 32'h7E04_0138, 32'h0,
             {9'h0BE, 9'h040, 9'h030, 9'h078}, 36'h0, 1'b0, 1'b0);

    // Backpressure: six back-to-back beats, downstream stalled in cycles 3..6.
    for (int k = 0; k < 6; k++) begin
      bp_a[k] = $urandom;
      bp_b[k] = $urandom;
    end
    d0 = n_deliv;
    idx = 0; cyc = 0;
    while ((idx < 6 || cyc < 8) && cyc < 40) begin
      out_ready_i = !(cyc >= 3 && cyc <= 6);
      in_valid_i  = (idx < 6);
      fmt_i       = 2'(idx % 2);
      a_i         = bp_a[idx % 6];
      b_i         = bp_b[idx % 6];
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      if (cyc >= 3 && cyc <= 6) chk("bp_in_ready_low", 128'(in_ready_o), 128'(0));
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    in_valid_i = 1'b0; out_ready_i = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("bp_delivered", 128'(n_deliv - d0), 128'(6));

    // Random traffic with random downstream stalls and mixed formats.
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int r;
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end else begin
        r = int'($urandom_range(0, 9));
        send((r < 5) ? 2'd0 : (r < 9) ? 2'd1 : 2'($urandom_range(2, 3)), $urandom, $urandom);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #2;
    out_ready_i = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("random_drained", 128'(exp_q.size()), 128'(0));

    // Reset with both stages full and stalled.
    out_ready_i = 1'b0;
    send(2'd0, 32'h3838_3838, 32'h0);
    send(2'd1, 32'h3C3C_3C3C, 32'h0);
    @(negedge clk);
    chk("full_before_reset", 128'({out_valid_o, in_ready_o}), 128'({1'b1, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_valid", 128'(out_valid_o), 128'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    out_ready_i = 1'b1;
    #1;
    chk("ready_after_midreset", 128'(in_ready_o), 128'(1));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("no_stale_beat", 128'(out_valid_o), 128'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_to_fp9_con_pipe
